// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, PSR flag bit positions and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_ADD     = 3'b011;
  localparam logic [2:0] OP_SUB     = 3'b100;
  localparam logic [2:0] OP_LSHIFT  = 3'b101;
  localparam logic [2:0] OP_RSHIFT  = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Flag vector layout is {C,L,F,Z,N}
  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU, zero latency, no flow control. Flags: C carry/borrow, L unsigned a<b,
// F signed overflow (ADD/SUB only), Z result zero, N result sign; illegal op gives all zeros.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        result       = sum[WIDTH-1:0];
        flags[FLG_C] = sum[WIDTH];
        flags[FLG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result       = diff[WIDTH-1:0];
        flags[FLG_C] = diff[WIDTH];
        flags[FLG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_LSHIFT: result = a << b[3:0];
      OP_RSHIFT: result = a >> b[3:0];
      default:   result = '0;
    endcase
    if (op != OP_ILLEGAL) begin
      flags[FLG_L] = (a < b);
      flags[FLG_Z] = (result == '0);
      flags[FLG_N] = result[WIDTH-1];
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational; a held lock on the last winner overrides the
// rotation. Grant is one-hot and never asserted without the matching valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (lock[last] && valid[last]) begin
      grant[last] = 1'b1;
    end else if (&valid) begin
      grant[!last] = 1'b1;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; response registered one cycle after accept, no
// response backpressure. Define ALU_ARB_LOCK_EN to let req_lock hold a grant across cycles.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NREQ  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_upd,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_upd,
  input  logic [NREQ-1:0]  req_lock,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic [4:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic [4:0]       psr
);

  logic [1:0]       grant;
  logic [1:0]       lock_eff;
  logic             last;
  logic             sel;
  logic             accept;
  logic             illegal;
  logic             upd;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_result;
  logic [4:0]       alu_flags;

`ifdef ALU_ARB_LOCK_EN
  // Remembers that the previous winner asked to keep the ALU; last names that winner.
  logic lock_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= accept && req_lock[sel];
    end
  end

  assign lock_eff = lock_q ? req_lock : 2'b00;
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign lock_eff    = 2'b00;
`endif

  rr_arb2 u_arb (
    .valid (req_valid),
    .lock  (lock_eff),
    .last  (last),
    .grant (grant)
  );

  assign req_ready = reset ? 2'b00 : grant;
  assign accept    = |req_ready;
  assign sel       = grant[1];

  // With no grant sel is 0, so the ALU simply sees port 0.
  assign op      = sel ? req1_op  : req0_op;
  assign a       = sel ? req1_a   : req0_a;
  assign b       = sel ? req1_b   : req0_b;
  assign upd     = sel ? req1_upd : req0_upd;
  assign illegal = (op == OP_ILLEGAL);

  alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid   <= '0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_illegal <= 1'b0;
      psr         <= '0;
      last        <= 1'b1;
    end else begin
      rsp_valid <= req_ready;
      if (accept) begin
        last        <= sel;
        rsp_result  <= illegal ? '0 : alu_result;
        rsp_flags   <= illegal ? 5'b0 : alu_flags;
        rsp_illegal <= illegal;
        if (upd && !illegal) begin
          psr <= alu_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes hand-computed responses into a queue,
// a negedge monitor pops and compares whenever rsp_valid is seen.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [2:0]  req0_op = 3'b0, req1_op = 3'b0;
  logic [15:0] req0_a = 16'h0, req0_b = 16'h0, req1_a = 16'h0, req1_b = 16'h0;
  logic        req0_upd = 1'b0, req1_upd = 1'b0;
  logic [1:0]  req_lock = 2'b00;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_illegal;
  logic [4:0]  psr;

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] res;
    logic [4:0]  flg;
    logic        ill;
    logic [4:0]  psr;
  } exp_t;

  exp_t       sbq[$];
  logic [4:0] model_psr = 5'b0;
  int         checks = 0;
  int         errors = 0;

  alu_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_upd    (req0_upd),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_upd    (req1_upd),
    .req_lock    (req_lock),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_illegal (rsp_illegal),
    .psr         (psr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic upd);
    if (p == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_upd = upd;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_upd = upd;
    end
  endtask

  // One cycle: check the grant, queue the expected response, advance past the edge.
  task automatic cycle(input logic [1:0] er, input logic [15:0] res, input logic [4:0] flg,
                       input logic ill, input logic upd);
    exp_t e;
    @(negedge clk);
    chk("req_ready", {30'b0, req_ready}, {30'b0, er});
    if (er != 2'b00) begin
      if (upd && !ill) model_psr = flg;
      e.vld = er; e.res = res; e.flg = flg; e.ill = ill; e.psr = model_psr;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    wait (reset === 1'b0);
    forever begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp got=%0h exp=none at %0t", rsp_valid, $time);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid",   {30'b0, rsp_valid},   {30'b0, e.vld});
          chk("rsp_result",  {16'b0, rsp_result},  {16'b0, e.res});
          chk("rsp_flags",   {27'b0, rsp_flags},   {27'b0, e.flg});
          chk("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, e.ill});
          chk("psr",         {27'b0, psr},         {27'b0, e.psr});
        end
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_ready",   {30'b0, req_ready},   32'h0);
    chk("rst_valid",   {30'b0, rsp_valid},   32'h0);
    chk("rst_result",  {16'b0, rsp_result},  32'h0);
    chk("rst_flags",   {27'b0, rsp_flags},   32'h0);
    chk("rst_illegal", {31'b0, rsp_illegal}, 32'h0);
    chk("rst_psr",     {27'b0, psr},         32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 2'b00;

    // Port 0 alone: 2+3, PSR takes the flags
    set_port(0, OP_ADD, 16'd2, 16'd3, 1'b1);
    req_valid = 2'b01;
    cycle(2'b01, 16'd5, 5'b01000, 1'b0, 1'b1);

    // Port 1 alone: OR of zeros sets Z, leaves last=1
    set_port(1, OP_OR, 16'h0, 16'h0, 1'b1);
    req_valid = 2'b10;
    cycle(2'b10, 16'h0, 5'b00010, 1'b0, 1'b1);

    // Sustained tie alternates 0,1,0,1
    set_port(0, OP_XOR, 16'h00FF, 16'h0F0F, 1'b0);
    set_port(1, OP_SUB, 16'd10, 16'd3, 1'b0);
    req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      cycle(2'b01, 16'h0FF0, 5'b01000, 1'b0, 1'b0);
      cycle(2'b10, 16'd7, 5'b00000, 1'b0, 1'b0);
    end

    req_valid = 2'b00;
    cycle(2'b00, 16'h0, 5'b0, 1'b0, 1'b0);

    // Carry out, result truncated, PSR held (upd=0)
    set_port(0, OP_ADD, 16'hFFFF, 16'hFFFF, 1'b0);
    req_valid = 2'b01;
    cycle(2'b01, 16'hFFFE, 5'b10001, 1'b0, 1'b0);

    // Illegal op with upd=1 leaves PSR alone
    set_port(1, OP_ILLEGAL, 16'd5, 16'd6, 1'b1);
    req_valid = 2'b10;
    cycle(2'b10, 16'h0, 5'b00000, 1'b1, 1'b1);

    // Shifts use only b[3:0]
    set_port(0, OP_LSHIFT, 16'h0001, 16'h0014, 1'b0);
    req_valid = 2'b01;
    cycle(2'b01, 16'h0010, 5'b01000, 1'b0, 1'b0);
    set_port(0, OP_RSHIFT, 16'h8000, 16'd15, 1'b0);
    cycle(2'b01, 16'h0001, 5'b00000, 1'b0, 1'b0);

    // SUB 1-65535 then reset in the following cycle
    set_port(1, OP_SUB, 16'd1, 16'hFFFF, 1'b1);
    req_valid = 2'b10;
    cycle(2'b10, 16'd2, 5'b11000, 1'b0, 1'b1);
    reset = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("ready_in_reset", {30'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 2'b00;
    model_psr = 5'b0;
    @(negedge clk);
    chk("post_rst_valid", {30'b0, rsp_valid}, 32'h0);
    chk("post_rst_psr",   {27'b0, psr},       32'h0);
    @(posedge clk);
    #1;

    // First tie after reset goes to port 0
    set_port(0, OP_AND, 16'hFFFF, 16'h00F0, 1'b0);
    set_port(1, OP_OR, 16'h1200, 16'h0034, 1'b0);
    req_valid = 2'b11;
    cycle(2'b01, 16'h00F0, 5'b00000, 1'b0, 1'b0);
    cycle(2'b10, 16'h1234, 5'b00000, 1'b0, 1'b0);

    // Lock on port 0 for three cycles
    req_lock = 2'b01;
`ifdef ALU_ARB_LOCK_EN
    for (int i = 0; i < 3; i++) cycle(2'b01, 16'h00F0, 5'b00000, 1'b0, 1'b0);
    req_lock = 2'b00;
    cycle(2'b10, 16'h1234, 5'b00000, 1'b0, 1'b0);
`else
    cycle(2'b01, 16'h00F0, 5'b00000, 1'b0, 1'b0);
    cycle(2'b10, 16'h1234, 5'b00000, 1'b0, 1'b0);
    cycle(2'b01, 16'h00F0, 5'b00000, 1'b0, 1'b0);
    req_lock = 2'b00;
    cycle(2'b10, 16'h1234, 5'b00000, 1'b0, 1'b0);
`endif

    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", sbq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
